// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared pipe encodings and pick record for the issue picker
package issue_pkg;

  localparam int PIPE_W = 4;

  localparam logic [PIPE_W-1:0] PIPE_ALU = 4'b0001;
  localparam logic [PIPE_W-1:0] PIPE_MUL = 4'b0010;
  localparam logic [PIPE_W-1:0] PIPE_MEM = 4'b0100;
  localparam logic [PIPE_W-1:0] PIPE_BRU = 4'b1000;

  localparam int DEF_ROB_W = 4;

  typedef struct packed {
    logic [DEF_ROB_W-1:0] dst_rob;
    logic [PIPE_W-1:0]    pipe;
  } issue_pick_t;

endpackage

// File: rtl/issue_age_matrix.sv
// rtl/issue_age_matrix.sv - relative-age matrix with an oldest-of(request) selector
module issue_age_matrix #(
  parameter int ENTRIES = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [ENTRIES-1:0]           i_alloc,
  input  logic [ENTRIES-1:0]           i_valid,
  input  logic [ENTRIES-1:0]           i_req,
  output logic [ENTRIES-1:0]           o_oldest,
  output logic [ENTRIES*ENTRIES-1:0]   o_older
);

  // older_q[i*ENTRIES+j] set means entry i is older than entry j
  logic [ENTRIES*ENTRIES-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    for (int k = 0; k < ENTRIES; k++) begin
      if (i_alloc[k]) begin
        for (int j = 0; j < ENTRIES; j++) older_d[k*ENTRIES+j] = 1'b0;
        for (int i = 0; i < ENTRIES; i++) if (i != k) older_d[i*ENTRIES+k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) older_q <= '0;
    else         older_q <= older_d;
  end

  always_comb begin
    o_oldest = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      o_oldest[i] = i_req[i] & i_valid[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && i_req[j] && i_valid[j] && older_q[j*ENTRIES+i]) o_oldest[i] = 1'b0;
      end
    end
  end

  assign o_older = older_q;

endmodule

// File: rtl/issue_pick_ooo_reg.sv
// rtl/issue_pick_ooo_reg.sv - oldest-ready issue pick with wakeup, masking and a registered output stage
module issue_pick_ooo_reg
  import issue_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int ROB_W     = 4,
  parameter int PAYLOAD_W = 100,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           snoop_hit,
  input  logic                           bco_valid,
  input  logic [ENTRIES-1:0]             i_alloc,
  input  logic [ENTRIES-1:0]             i_valid,
  input  logic [ENTRIES*ROB_W-1:0]       i_src0_rob,
  input  logic [ENTRIES*ROB_W-1:0]       i_src1_rob,
  input  logic [ENTRIES-1:0]             i_src0_rdy,
  input  logic [ENTRIES-1:0]             i_src1_rdy,
  input  logic                           i_wb_valid,
  input  logic [ROB_W-1:0]               i_wb_rob,
  input  logic [ENTRIES-1:0]             i_load,
  input  logic [ENTRIES-1:0]             i_store,
  input  logic [ENTRIES*PIPE_W-1:0]      i_pipe,
  input  logic [PIPE_W-1:0]              i_pipe_busy,
  input  logic [ENTRIES*ROB_W-1:0]       i_dst_rob,
  input  logic [ENTRIES*PAYLOAD_W-1:0]   i_payload,
  output logic [ENTRIES-1:0]             o_en,
  output logic [IDX_W-1:0]               o_pick,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [ROB_W-1:0]               o_dst_rob,
  output logic [PIPE_W-1:0]              o_pipe,
  output logic [PAYLOAD_W-1:0]           o_payload
);

  logic [ENTRIES-1:0]         src0_ok, src1_ok, blk_ld, cand, gnt;
  logic [ENTRIES*ENTRIES-1:0] older;
  logic [IDX_W-1:0]           pick;
  logic                       flush, can_load, issue;

  logic                 valid_q, valid_d;
  logic [ROB_W-1:0]     dst_q, dst_d;
  logic [PIPE_W-1:0]    pipe_q, pipe_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  // Same-cycle writeback bypass lets a just-woken entry compete in this pick
  always_comb begin
    src0_ok = '0;
    src1_ok = '0;
    blk_ld  = '0;
    cand    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      src0_ok[i] = i_src0_rdy[i] | (i_wb_valid & (i_wb_rob == i_src0_rob[i*ROB_W +: ROB_W]));
      src1_ok[i] = i_src1_rdy[i] | (i_wb_valid & (i_wb_rob == i_src1_rob[i*ROB_W +: ROB_W]));
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && i_valid[j] && i_store[j] && older[j*ENTRIES+i]) blk_ld[i] = i_load[i];
      end
      cand[i] = i_valid[i] & src0_ok[i] & src1_ok[i] & ~i_alloc[i] & ~blk_ld[i]
              & ~|(i_pipe[i*PIPE_W +: PIPE_W] & i_pipe_busy);
    end
  end

  issue_age_matrix #(.ENTRIES(ENTRIES)) u_age (
    .clk      (clk),
    .resetn   (resetn),
    .i_alloc  (i_alloc),
    .i_valid  (i_valid),
    .i_req    (cand),
    .o_oldest (gnt),
    .o_older  (older)
  );

  always_comb begin
    pick = '0;
    for (int i = 0; i < ENTRIES; i++) if (gnt[i]) pick = IDX_W'(i);
  end

  assign flush    = snoop_hit | bco_valid;
  assign can_load = ~valid_q | i_ready;
  assign issue    = (|gnt) & can_load & ~flush & resetn;
  assign o_en     = issue ? gnt : '0;
  assign o_pick   = pick;

  always_comb begin
    valid_d   = valid_q;
    dst_d     = dst_q;
    pipe_d    = pipe_q;
    payload_d = payload_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (issue) begin
      valid_d   = 1'b1;
      dst_d     = i_dst_rob[pick*ROB_W +: ROB_W];
      pipe_d    = i_pipe[pick*PIPE_W +: PIPE_W];
      payload_d = i_payload[pick*PAYLOAD_W +: PAYLOAD_W];
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      dst_q     <= '0;
      pipe_q    <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      dst_q     <= dst_d;
      pipe_q    <= pipe_d;
      payload_q <= payload_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_dst_rob = dst_q;
  assign o_pipe    = pipe_q;
  assign o_payload = payload_q;

endmodule

// File: tb/tb_issue_pick_ooo_reg.sv
// tb/tb_issue_pick_ooo_reg.sv - scoreboard bench with an age-by-sequence-number queue model
module tb_issue_pick_ooo_reg;

  localparam int E  = 4;
  localparam int RW = 4;
  localparam int PW = 100;

  logic clk = 1'b0;
  logic resetn, snoop_hit, bco_valid, i_wb_valid, i_ready, o_valid;
  logic [E-1:0]    i_alloc, i_valid, i_src0_rdy, i_src1_rdy, i_load, i_store, o_en;
  logic [E*RW-1:0] i_src0_rob, i_src1_rob, i_dst_rob;
  logic [RW-1:0]   i_wb_rob, o_dst_rob;
  logic [E*4-1:0]  i_pipe;
  logic [3:0]      i_pipe_busy, o_pipe;
  logic [E*PW-1:0] i_payload;
  logic [1:0]      o_pick;
  logic [PW-1:0]   o_payload;

  issue_pick_ooo_reg #(.ENTRIES(E), .ROB_W(RW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
    .i_alloc(i_alloc), .i_valid(i_valid), .i_src0_rob(i_src0_rob), .i_src1_rob(i_src1_rob),
    .i_src0_rdy(i_src0_rdy), .i_src1_rdy(i_src1_rdy), .i_wb_valid(i_wb_valid), .i_wb_rob(i_wb_rob),
    .i_load(i_load), .i_store(i_store), .i_pipe(i_pipe), .i_pipe_busy(i_pipe_busy),
    .i_dst_rob(i_dst_rob), .i_payload(i_payload), .o_en(o_en), .o_pick(o_pick),
    .o_valid(o_valid), .i_ready(i_ready), .o_dst_rob(o_dst_rob), .o_pipe(o_pipe),
    .o_payload(o_payload)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] dst;
    logic [3:0]    pipe;
    logic [PW-1:0] pl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  bit            v[E], alloc_v[E], s0k[E], s1k[E], ld[E], st[E];
  int            seq[E];
  int            seq_cnt;
  logic [RW-1:0] s0r[E], s1r[E], dst[E];
  logic [3:0]    pp[E];
  logic [PW-1:0] pl[E];
  bit            wbv, rdy, snp, bco, mov;
  logic [RW-1:0] wbr;
  logic [3:0]    busy;
  logic [E-1:0]  last_en;
  logic [1:0]    last_pick;
  logic [PW-1:0] held_pl;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < E; k++) begin
      i_alloc[k]    = alloc_v[k];
      i_valid[k]    = v[k];
      i_src0_rdy[k] = s0k[k];
      i_src1_rdy[k] = s1k[k];
      i_load[k]     = ld[k];
      i_store[k]    = st[k];
      i_src0_rob[k*RW +: RW] = s0r[k];
      i_src1_rob[k*RW +: RW] = s1r[k];
      i_dst_rob[k*RW +: RW]  = dst[k];
      i_pipe[k*4 +: 4]       = pp[k];
      i_payload[k*PW +: PW]  = pl[k];
    end
    i_wb_valid  = wbv;
    i_wb_rob    = wbr;
    i_pipe_busy = busy;
    i_ready     = rdy;
    snoop_hit   = snp;
    bco_valid   = bco;
  endtask

  // Oldest = smallest allocation sequence number among eligible entries
  function automatic int model_pick();
    int best = -1;
    for (int i = 0; i < E; i++) begin
      bit ok0, ok1, blk;
      if (!v[i] || alloc_v[i]) continue;
      ok0 = s0k[i] || (wbv && wbr == s0r[i]);
      ok1 = s1k[i] || (wbv && wbr == s1r[i]);
      if (!ok0 || !ok1) continue;
      if ((pp[i] & busy) != 4'b0) continue;
      blk = 1'b0;
      if (ld[i]) for (int j = 0; j < E; j++) if (v[j] && st[j] && seq[j] < seq[i]) blk = 1'b1;
      if (blk) continue;
      if (best < 0 || seq[i] < seq[best]) best = i;
    end
    return best;
  endfunction

  task automatic alloc(input int k, input bit r0, input logic [RW-1:0] rb0, input bit r1,
                       input bit l, input bit s, input logic [3:0] pipe, input logic [RW-1:0] d);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    s0k[k] = r0; s0r[k] = rb0; s1k[k] = r1; s1r[k] = RW'($urandom);
    ld[k] = l; st[k] = s; pp[k] = pipe; dst[k] = d; pl[k] = r[PW-1:0];
    alloc_v[k] = 1'b1;
    seq[k] = seq_cnt++;
  endtask

  task automatic step();
    int p;
    bit en, fl;
    logic [E-1:0] een;
    drive();
    @(negedge clk);
    p  = model_pick();
    fl = snp || bco;
    en = (p >= 0) && (!mov || rdy) && !fl;
    een = '0;
    if (en) een[p] = 1'b1;
    chk("o_en", 128'(o_en), 128'(een));
    chk("o_pick", 128'(o_pick), 128'(p >= 0 ? p : 0));
    chk("o_valid", 128'(o_valid), 128'(mov));
    last_en   = o_en;
    last_pick = o_pick;
    if (en) sb.push_back('{dst[p], pp[p], pl[p]});
    @(posedge clk);
    #1;
    mov = fl ? 1'b0 : en ? 1'b1 : rdy ? 1'b0 : mov;
    if (en) v[p] = 1'b0;
    for (int k = 0; k < E; k++) begin
      if (alloc_v[k]) begin v[k] = 1'b1; alloc_v[k] = 1'b0; end
      if (wbv && s0r[k] == wbr) s0k[k] = 1'b1;
      if (wbv && s1r[k] == wbr) s1k[k] = 1'b1;
    end
    wbv = 1'b0; snp = 1'b0; bco = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int k = 0; k < E; k++) begin
      v[k] = 0; alloc_v[k] = 0; s0k[k] = 0; s1k[k] = 0; ld[k] = 0; st[k] = 0; seq[k] = 0;
      s0r[k] = '0; s1r[k] = '0; dst[k] = '0; pp[k] = '0; pl[k] = '0;
    end
    seq_cnt = 0; wbv = 0; wbr = '0; busy = '0; rdy = 1; snp = 0; bco = 0; mov = 0;
    sb.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Monitor: every op leaving the output register is matched against the scoreboard
  always @(negedge clk) begin
    if (resetn === 1'b1 && o_valid === 1'b1 && (snoop_hit || bco_valid || i_ready)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty o_valid=1 with no expected op");
      end else begin
        mon_e = sb.pop_front();
        if (!(snoop_hit || bco_valid)) begin
          chk("out_dst", 128'(o_dst_rob), 128'(mon_e.dst));
          chk("out_pipe", 128'(o_pipe), 128'(mon_e.pipe));
          chk("out_payload", 128'(o_payload), 128'(mon_e.pl));
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    do_reset();
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_en", 128'(o_en), 128'(0));
    chk("rst_dst", 128'(o_dst_rob), 128'(0));
    chk("rst_payload", 128'(o_payload), 128'(0));

    // In-order allocation 2, 0, 3 issues in that order
    alloc(2, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd1); step();
    alloc(0, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd2); step(); chk("t1_pick0", 128'(last_pick), 128'(2));
    alloc(3, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd3); step(); chk("t1_pick1", 128'(last_pick), 128'(0));
    step(); chk("t1_pick2", 128'(last_pick), 128'(3));
    chk("t1_ovalid", 128'(o_valid), 128'(1));
    step(); step();

    // Writeback wakeup issues in the same cycle
    do_reset();
    alloc(1, 0, 4'd5, 1, 0, 0, 4'b0001, 4'd7); step();
    step(); chk("t2_wait", 128'(last_en), 128'(0));
    wbv = 1; wbr = 4'd5; step(); chk("t2_wake", 128'(last_en), 128'(4'b0010));
    chk("t2_ovalid", 128'(o_valid), 128'(1));
    step();

    // Younger load waits for an older unready store
    do_reset();
    alloc(0, 0, 4'd7, 1, 0, 1, 4'b0100, 4'd4); step();
    alloc(1, 1, 4'd0, 1, 1, 0, 4'b0100, 4'd5); step();
    step(); chk("t3_blocked", 128'(last_en), 128'(0));
    wbv = 1; wbr = 4'd7; step(); chk("t3_store", 128'(last_pick), 128'(0));
    step(); chk("t3_load", 128'(last_pick), 128'(1));
    step();

    // Busy MUL pipe lets a younger ALU op go first
    do_reset();
    busy = 4'b0010;
    alloc(0, 1, 4'd0, 1, 0, 0, 4'b0010, 4'd8); step();
    alloc(2, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd9); step();
    step(); chk("t4_alu", 128'(last_en), 128'(4'b0100));
    busy = 4'b0000;
    step(); chk("t4_mul", 128'(last_pick), 128'(0));
    step();

    // Stall holds the op; branch correction then kills it
    do_reset();
    rdy = 0;
    alloc(0, 1, 4'd0, 1, 0, 0, 4'b1000, 4'd10); step();
    step();
    alloc(1, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd11); step();
    held_pl = o_payload;
    for (int c = 0; c < 3; c++) begin
      step(); chk("t5_stall_en", 128'(last_en), 128'(0));
    end
    chk("t5_hold", 128'(o_payload), 128'(held_pl));
    bco = 1; step(); chk("t5_flush_en", 128'(last_en), 128'(0));
    chk("t5_flush_valid", 128'(o_valid), 128'(0));
    rdy = 1; step(); chk("t5_after", 128'(last_pick), 128'(1));
    step();

    // Reset during a stall drops the held op at once
    do_reset();
    rdy = 0;
    alloc(2, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd9); step();
    step();
    chk("t6_loaded", 128'(o_valid), 128'(1));
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid", 128'(o_valid), 128'(0));
    chk("t6_dst", 128'(o_dst_rob), 128'(0));
    chk("t6_payload", 128'(o_payload), 128'(0));
    chk("t6_en", 128'(o_en), 128'(0));
    do_reset();
    alloc(3, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd1); step();
    alloc(1, 1, 4'd0, 1, 0, 0, 4'b0001, 4'd2); step(); chk("t6_first", 128'(last_pick), 128'(3));
    step(); chk("t6_second", 128'(last_pick), 128'(1));
    step();

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        int k, cls;
        logic [3:0] pipe;
        k = int'($urandom_range(E-1, 0));
        cls = int'($urandom_range(3, 0));
        case ($urandom_range(2, 0))
          0: pipe = 4'b0001;
          1: pipe = 4'b0010;
          default: pipe = 4'b1000;
        endcase
        if (cls < 2) pipe = 4'b0100;
        if (!v[k] && !alloc_v[k])
          alloc(k, $urandom_range(1, 0) == 1, RW'($urandom), $urandom_range(1, 0) == 1,
                cls == 0, cls == 1, pipe, RW'($urandom));
      end
      wbv  = $urandom_range(99, 0) < 40;
      wbr  = RW'($urandom);
      busy = 4'($urandom & $urandom);
      rdy  = $urandom_range(9, 0) < 7;
      snp  = $urandom_range(39, 0) == 0;
      bco  = $urandom_range(39, 0) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
